// File: rtl/encoder_pkg.sv
// Shared types and helpers for the matrix encoder datapath.
// Slices are 5x5 bit planes; bit 5*y+x holds lane (x,y).
package encoder_pkg;

    localparam int SLICE_W = 25;
    localparam int LANES   = 5;

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    function automatic int idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/col_parity_stage_if.sv
// Slice stream bundle between the encoder stages.
// master is the surrounding datapath, slave is the stage.
interface col_parity_stage_if;
    import encoder_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [SLICE_W-1:0] in_slice;
    logic               out_valid;
    logic               out_ready;
    logic [SLICE_W-1:0] out_slice;
    logic               out_last;

    modport master (
        output in_valid,
        output in_slice,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_slice,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_slice,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_slice,
        output out_last
    );

endinterface

// File: rtl/col_parity_stage_counter.sv
// Generic up/down counter primitive; select=1 counts up.
module up_down_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         select,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= select ? q + W'(1) : q - W'(1);
        end
    end

endmodule

// File: rtl/col_parity_stage_slice_parity.sv
// Column parity of one slice: XOR of the five rows per column x.
module slice_parity
    import encoder_pkg::*;
(
    input  logic [SLICE_W-1:0] slice,
    output logic [LANES-1:0]   par
);

    always_comb begin
        par = '0;
        for (int y = 0; y < LANES; y++) begin
            for (int x = 0; x < LANES; x++) begin
                par[x] = par[x] ^ slice[idx(x, y)];
            end
        end
    end

endmodule

// File: rtl/col_parity_stage.sv
// Theta-style column parity stage: buffers a frame, then emits mixed slices.
// Optional COL_PARITY_BYPASS_EN adds a per-frame bypass input.
module col_parity_stage
    import encoder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    col_parity_stage_if.slave  s,
`ifdef COL_PARITY_BYPASS_EN
    input  logic               bypass,
`endif
    output logic               busy
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   prev;
    logic               at_end;
    logic               in_hs;
    logic               out_hs;
    logic [LANES-1:0]   par_in;
    logic [LANES-1:0]   pc;
    logic [LANES-1:0]   pp;
    logic [SLICE_W-1:0] a;
    logic [SLICE_W-1:0] mixed;

    logic [SLICE_W-1:0] slice_mem [DEPTH];
    logic [LANES-1:0]   par_mem   [DEPTH];

    assign at_end = (cnt == CNT_W'(DEPTH - 1));
    assign in_hs  = (state_q == LOAD) && s.in_valid;
    assign out_hs = (state_q == EMIT) && s.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (in_hs && at_end) state_d = EMIT;
            EMIT: if (out_hs && at_end) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        s.in_ready  = (state_q == LOAD);
        s.out_valid = (state_q == EMIT);
        s.out_last  = (state_q == EMIT) && at_end;
        busy        = (state_q == EMIT);
    end

    // DEPTH is a power of two, so the natural wrap returns cnt to 0
    up_down_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (in_hs || out_hs),
        .select (1'b1),
        .q      (cnt)
    );

    slice_parity u_par (
        .slice (s.in_slice),
        .par   (par_in)
    );

    always_ff @(posedge clk) begin
        if (in_hs) begin
            slice_mem[cnt] <= s.in_slice;
            par_mem[cnt]   <= par_in;
        end
    end

    assign prev = cnt - CNT_W'(1);
    assign a    = slice_mem[cnt];
    assign pc   = par_mem[cnt];
    assign pp   = par_mem[prev];

    always_comb begin
        mixed = '0;
        for (int y = 0; y < LANES; y++) begin
            for (int x = 0; x < LANES; x++) begin
                mixed[idx(x, y)] = a[idx(x, y)]
                                 ^ pc[(x + 4) % 5]
                                 ^ pp[(x + 1) % 5];
            end
        end
    end

`ifdef COL_PARITY_BYPASS_EN
    logic byp_q;

    // Latched with the first slice so the whole frame sees one mode
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q <= 1'b0;
        end else if (in_hs && cnt == '0) begin
            byp_q <= bypass;
        end
    end

    assign s.out_slice = byp_q ? a : mixed;
`else
    assign s.out_slice = mixed;
`endif

endmodule

// File: tb/tb_col_parity_stage.sv
// Directed bench for col_parity_stage with hand-computed frames.
// Bypass checks are compiled when COL_PARITY_BYPASS_EN is defined.
module tb_col_parity_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic byp_drive = 1'b0;

    always #5 clk = ~clk;

    col_parity_stage_if bus ();

    col_parity_stage #(
        .DEPTH (64),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (bus.slave),
`ifdef COL_PARITY_BYPASS_EN
        .bypass (byp_drive),
`endif
        .busy   (busy)
    );

    int passed = 0;
    int total  = 0;

    logic [24:0] frame [64];
    logic [24:0] expv  [64];

    task automatic chk(input string tag, input logic [24:0] o,
                       input logic [24:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < 64; i++) begin
            frame[i] = '0;
            expv[i]  = '0;
        end
    endtask

    task automatic send_frame(input bit bf, input bit br);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 0)
                chk("ld_ready", 25'(bus.in_ready), 25'd1);
            if (i == 63)
                chk("ld_no_valid", 25'(bus.out_valid), 25'd0);
            bus.in_valid  = 1'b1;
            bus.in_slice  = frame[i];
            byp_drive     = (i == 0) ? bf : br;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_slice = '0;
        byp_drive    = 1'b0;
        chk("emit_start", 25'(bus.out_valid), 25'd1);
        chk("emit_busy", 25'(busy), 25'd1);
        chk("emit_no_ready", 25'(bus.in_ready), 25'd0);
    endtask

    task automatic drain(input int abort_at, input int stall_at);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == abort_at) return;
            chk($sformatf("slice%0d", i), bus.out_slice, expv[i]);
            chk($sformatf("last%0d", i), 25'(bus.out_last),
                25'(i == 63));
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_slice  = 25'h1abcdef;
                repeat (2) begin
                    step();
                    chk("stall_slice", bus.out_slice, expv[i]);
                    chk("stall_ready", 25'(bus.in_ready), 25'd0);
                    chk("stall_valid", 25'(bus.out_valid), 25'd1);
                end
                bus.out_ready = 1'b1;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_slice = '0;
        chk("done_valid", 25'(bus.out_valid), 25'd0);
        chk("done_ready", 25'(bus.in_ready), 25'd1);
        chk("done_busy", 25'(busy), 25'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_slice  = '0;
        bus.out_ready = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (2) step();
        chk("rst_in_ready", 25'(bus.in_ready), 25'd1);
        chk("rst_out_valid", 25'(bus.out_valid), 25'd0);
        chk("rst_out_last", 25'(bus.out_last), 25'd0);
        chk("rst_busy", 25'(busy), 25'd0);
        rst = 1'b0;
        step();

        // all-zero frame
        clear();
        send_frame(1'b0, 1'b0);
        drain(-1, -1);

        // single bit in slice 0
        clear();
        frame[0] = 25'h0000001;
        expv[0]  = 25'h0210843;
        expv[1]  = 25'h1084210;
        send_frame(1'b0, 1'b0);
        drain(-1, -1);

        // single bit in slice 63 wraps into slice 0
        clear();
        frame[63] = 25'h0000001;
        expv[63]  = 25'h0210843;
        expv[0]   = 25'h1084210;
        send_frame(1'b0, 1'b0);
        drain(-1, -1);

        // even column parity leaves the slice untouched
        clear();
        frame[5] = 25'h0000021;
        expv[5]  = 25'h0000021;
        send_frame(1'b0, 1'b0);
        drain(-1, -1);

        // distinct even-parity slices, stalled in EMIT
        clear();
        for (int i = 0; i < 64; i++) begin
            logic [4:0] lo;
            logic [4:0] hi;
            lo = 5'(i);
            hi = {4'b0, 1'(i >> 5)};
            frame[i] = {5'b0, hi, hi, lo, lo};
            expv[i]  = frame[i];
        end
        send_frame(1'b0, 1'b0);
        drain(-1, 10);

        // reset in the middle of EMIT
        clear();
        frame[0] = 25'h0000001;
        expv[0]  = 25'h0210843;
        expv[1]  = 25'h1084210;
        send_frame(1'b0, 1'b0);
        drain(30, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_in_ready", 25'(bus.in_ready), 25'd1);
        chk("abort_out_valid", 25'(bus.out_valid), 25'd0);
        chk("abort_busy", 25'(busy), 25'd0);
        send_frame(1'b0, 1'b0);
        drain(-1, -1);

`ifdef COL_PARITY_BYPASS_EN
        // bypass on first slice: outputs equal inputs
        clear();
        frame[0] = 25'h0000001;
        expv[0]  = 25'h0000001;
        send_frame(1'b1, 1'b0);
        drain(-1, -1);

        // bypass only on later slices: parity still applied
        clear();
        frame[0] = 25'h0000001;
        expv[0]  = 25'h0210843;
        expv[1]  = 25'h1084210;
        send_frame(1'b0, 1'b1);
        drain(-1, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
